// File: rtl/seq_lock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_lock_fsm                                                 |
// | Description : Time-windowed combination lock. One password bit is entered  |
// |               per window (press seen = 1). The entry is compared against a |
// |               secret captured at start, and an active-low RGB LED shows    |
// |               prompt / success / fail / lockout.                           |
// | Config      : define SEQ_LOCK_LOCKOUT_EN to enable the attempt limit and   |
// |               the LOCKOUT state; otherwise FAIL always returns to IDLE.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module seq_lock_fsm #(
   parameter int PW_LEN         = 10,
   parameter int WINDOW_CYCLES  = 24_000_000,
   parameter int COLOR_CYCLES   = 24_000_000,
   parameter int FAIL_CYCLES    = 48_000_000,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int LOCKOUT_CYCLES = 240_000_000
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start_pulse,
   input  logic                                  bit_pulse,
   input  logic [PW_LEN-1:0]                     secret,
   output logic [2:0]                            led,
   output logic                                  unlocked,
   output logic                                  locked_out,
   output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts
);

`ifdef SEQ_LOCK_LOCKOUT_EN
   localparam bit LOCKOUT_EN = 1'b1;
`else
   localparam bit LOCKOUT_EN = 1'b0;
`endif

   // Counter widths: each counter holds 0..terminal, never less than one bit
   localparam int WIN_W  = (WINDOW_CYCLES > 1)       ? $clog2(WINDOW_CYCLES)     : 1;
   localparam int HALF_W = ((WINDOW_CYCLES / 2) > 1) ? $clog2(WINDOW_CYCLES / 2) : 1;
   localparam int COL_W  = (COLOR_CYCLES > 1)        ? $clog2(COLOR_CYCLES)      : 1;
   localparam int FAIL_W = (FAIL_CYCLES > 1)         ? $clog2(FAIL_CYCLES)       : 1;
   localparam int LOCK_W = (LOCKOUT_CYCLES > 1)      ? $clog2(LOCKOUT_CYCLES)    : 1;
   localparam int IDX_W  = (PW_LEN > 1)              ? $clog2(PW_LEN)            : 1;
   localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);

   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [WIN_W-1:0]  WIN_HALF  = WIN_W'(WINDOW_CYCLES / 2);
   localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'((WINDOW_CYCLES / 2) - 1);
   localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLOR_CYCLES - 1);
   localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(FAIL_CYCLES - 1);
   localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PW_LEN - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
   localparam logic [ATT_W-1:0]  ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
   localparam logic [ATT_W-1:0]  ATT_ONE   = ATT_W'(1);

   // Active-low RGB encodings
   localparam logic [2:0] LED_RED   = 3'b110;
   localparam logic [2:0] LED_BLUE  = 3'b011;
   localparam logic [2:0] LED_GREEN = 3'b101;
   localparam logic [2:0] LED_OFF   = 3'b111;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      SUCCESS = 3'd3,
      FAIL    = 3'd4,
      LOCKOUT = 3'd5
   } state_t;

   state_t              state;
   logic [PW_LEN-1:0]   secret_q;
   logic [PW_LEN-1:0]   entry;
   logic                hit;
   logic [WIN_W-1:0]    win_cnt;
   logic [IDX_W-1:0]    bit_idx;
   logic [COL_W-1:0]    col_cnt;
   logic [1:0]          col_sel;
   logic [FAIL_W-1:0]   fail_cnt;
   logic [LOCK_W-1:0]   lock_cnt;
   logic [HALF_W-1:0]   half_cnt;

   // Lock sequencer: state, counters and all registered outputs advance together,
   // so every output always matches the state it is registered alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         secret_q   <= '0;
         entry      <= '0;
         hit        <= 1'b0;
         win_cnt    <= '0;
         bit_idx    <= '0;
         col_cnt    <= '0;
         col_sel    <= 2'd0;
         fail_cnt   <= '0;
         lock_cnt   <= '0;
         half_cnt   <= '0;
         led        <= LED_OFF;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
         attempts   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_pulse) begin
                  state    <= ENTRY;
                  secret_q <= secret;
                  win_cnt  <= '0;
                  bit_idx  <= '0;
                  hit      <= 1'b0;
                  led      <= LED_RED;
               end
            end

            ENTRY: begin
               if (win_cnt == WIN_LAST) begin
                  // A press on the final cycle of the window still counts
                  entry[bit_idx] <= hit | bit_pulse;
                  hit            <= 1'b0;
                  win_cnt        <= '0;
                  if (bit_idx == IDX_LAST) begin
                     state <= CHECK;
                     led   <= LED_OFF;
                  end else begin
                     bit_idx <= bit_idx + IDX_ONE;
                     led     <= LED_RED;
                  end
               end else begin
                  if (bit_pulse) begin
                     hit <= 1'b1;
                  end
                  win_cnt <= win_cnt + WIN_ONE;
                  led     <= ((win_cnt + WIN_ONE) < WIN_HALF) ? LED_RED : LED_OFF;
               end
            end

            CHECK: begin
               if (entry == secret_q) begin
                  state    <= SUCCESS;
                  attempts <= '0;
                  unlocked <= 1'b1;
                  led      <= LED_RED;
                  col_cnt  <= '0;
                  col_sel  <= 2'd0;
               end else begin
                  state    <= FAIL;
                  led      <= LED_RED;
                  fail_cnt <= '0;
                  if (attempts != ATT_MAX) begin
                     attempts <= attempts + ATT_ONE;
                  end
               end
            end

            SUCCESS: begin
               if (start_pulse) begin
                  state    <= IDLE;
                  unlocked <= 1'b0;
                  led      <= LED_OFF;
               end else if (col_cnt == COL_LAST) begin
                  col_cnt <= '0;
                  case (col_sel)
                     2'd0: begin
                        col_sel <= 2'd1;
                        led     <= LED_BLUE;
                     end
                     2'd1: begin
                        col_sel <= 2'd2;
                        led     <= LED_GREEN;
                     end
                     default: begin
                        col_sel <= 2'd0;
                        led     <= LED_RED;
                     end
                  endcase
               end else begin
                  col_cnt <= col_cnt + COL_ONE;
               end
            end

            FAIL: begin
               if (fail_cnt == FAIL_LAST) begin
                  if (LOCKOUT_EN && (attempts == ATT_MAX)) begin
                     state      <= LOCKOUT;
                     locked_out <= 1'b1;
                     led        <= LED_RED;
                     lock_cnt   <= '0;
                     half_cnt   <= '0;
                  end else begin
                     state <= IDLE;
                     led   <= LED_OFF;
                  end
               end else begin
                  fail_cnt <= fail_cnt + FAIL_ONE;
               end
            end

            LOCKOUT: begin
               if (lock_cnt == LOCK_LAST) begin
                  state      <= IDLE;
                  attempts   <= '0;
                  locked_out <= 1'b0;
                  led        <= LED_OFF;
               end else begin
                  lock_cnt <= lock_cnt + LOCK_ONE;
                  if (half_cnt == HALF_LAST) begin
                     half_cnt <= '0;
                     led      <= (led == LED_RED) ? LED_OFF : LED_RED;
                  end else begin
                     half_cnt <= half_cnt + HALF_ONE;
                  end
               end
            end

            default: begin
               state      <= IDLE;
               led        <= LED_OFF;
               unlocked   <= 1'b0;
               locked_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_lock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_lock_fsm                                              |
// | Description : Directed self-checking bench for seq_lock_fsm with small     |
// |               timing parameters. Lockout checks follow the build macro     |
// |               SEQ_LOCK_LOCKOUT_EN.                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_seq_lock_fsm;

   localparam int PW_LEN         = 4;
   localparam int WINDOW_CYCLES  = 8;
   localparam int COLOR_CYCLES   = 4;
   localparam int FAIL_CYCLES    = 6;
   localparam int MAX_ATTEMPTS   = 2;
   localparam int LOCKOUT_CYCLES = 20;

   localparam logic [2:0] RED   = 3'b110;
   localparam logic [2:0] BLUE  = 3'b011;
   localparam logic [2:0] GREEN = 3'b101;
   localparam logic [2:0] OFF   = 3'b111;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_pulse;
   logic              bit_pulse;
   logic [PW_LEN-1:0] secret;
   logic [2:0]        led;
   logic              unlocked;
   logic              locked_out;
   logic [1:0]        attempts;

   int n_checks = 0;
   int n_fail   = 0;

   seq_lock_fsm #(
      .PW_LEN         (PW_LEN),
      .WINDOW_CYCLES  (WINDOW_CYCLES),
      .COLOR_CYCLES   (COLOR_CYCLES),
      .FAIL_CYCLES    (FAIL_CYCLES),
      .MAX_ATTEMPTS   (MAX_ATTEMPTS),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_pulse (start_pulse),
      .bit_pulse   (bit_pulse),
      .secret      (secret),
      .led         (led),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .attempts    (attempts)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start from IDLE; afterwards the DUT is in window 0, cycle 0 of entry
   task automatic start_entry(input logic [PW_LEN-1:0] sec);
      secret      = sec;
      start_pulse = 1'b1;
      tick();
      start_pulse = 1'b0;
   endtask

   // Run ncyc entry cycles; window w gets presses on cycles c where pat[w] && mask[c]
   task automatic drive_entry(input logic [PW_LEN-1:0] pat, input logic [7:0] mask,
                              input int ncyc, input logic corrupt_secret);
      for (int k = 0; k < ncyc; k++) begin
         int w;
         int c;
         w = k / WINDOW_CYCLES;
         c = k % WINDOW_CYCLES;
         check_val("entry_led", 32'(led), 32'((c < WINDOW_CYCLES / 2) ? RED : OFF));
         if (corrupt_secret && k == 10) secret = 4'b1111;
         bit_pulse = pat[w] && mask[c];
         tick();
      end
      bit_pulse = 1'b0;
   endtask

   // From the CHECK cycle: expect success and the colour cycle, then relock
   task automatic expect_success();
      check_val("check_led", 32'(led), 32'(OFF));
      check_val("check_unlocked", 32'(unlocked), 32'd0);
      tick();
      for (int i = 0; i < 13; i++) begin
         logic [2:0] exp_led;
         case ((i / COLOR_CYCLES) % 3)
            0:       exp_led = RED;
            1:       exp_led = BLUE;
            default: exp_led = GREEN;
         endcase
         check_val("success_led", 32'(led), 32'(exp_led));
         check_val("success_unlocked", 32'(unlocked), 32'd1);
         tick();
      end
      check_val("success_attempts", 32'(attempts), 32'd0);
      start_pulse = 1'b1;
      tick();
      start_pulse = 1'b0;
      check_val("relock_unlocked", 32'(unlocked), 32'd0);
      check_val("relock_led", 32'(led), 32'(OFF));
   endtask

   // From the CHECK cycle: expect FAIL for FAIL_CYCLES with start ignored
   task automatic expect_fail(input int exp_att);
      check_val("check_led", 32'(led), 32'(OFF));
      tick();
      for (int i = 0; i < FAIL_CYCLES; i++) begin
         check_val("fail_led", 32'(led), 32'(RED));
         check_val("fail_attempts", 32'(attempts), 32'(exp_att));
         check_val("fail_unlocked", 32'(unlocked), 32'd0);
         start_pulse = (i == 2);
         tick();
      end
      start_pulse = 1'b0;
   endtask

   // Post-FAIL IDLE check
   task automatic expect_idle(input int exp_att);
      check_val("idle_led", 32'(led), 32'(OFF));
      check_val("idle_locked_out", 32'(locked_out), 32'd0);
      check_val("idle_attempts", 32'(attempts), 32'(exp_att));
      tick();
      check_val("idle_stays_led", 32'(led), 32'(OFF));
   endtask

   initial begin
      rst         = 1'b1;
      start_pulse = 1'b0;
      bit_pulse   = 1'b0;
      secret      = '0;
      tick();
      tick();
      check_val("rst_led", 32'(led), 32'(OFF));
      check_val("rst_unlocked", 32'(unlocked), 32'd0);
      check_val("rst_locked_out", 32'(locked_out), 32'd0);
      check_val("rst_attempts", 32'(attempts), 32'd0);
      rst = 1'b0;
      tick();

      // bit_pulse in IDLE does nothing
      bit_pulse = 1'b1;
      tick();
      bit_pulse = 1'b0;
      check_val("idle_bit_ignored", 32'(led), 32'(OFF));

      // Correct entry, press on the last cycle of each '1' window, secret changed mid-entry
      start_entry(4'b0101);
      drive_entry(4'b0101, 8'b1000_0000, PW_LEN * WINDOW_CYCLES, 1'b1);
      expect_success();

      // Empty entry -> first failure
      start_entry(4'b0101);
      drive_entry(4'b0000, 8'b0000_0000, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_fail(1);
      expect_idle(1);

`ifdef SEQ_LOCK_LOCKOUT_EN
      // Second consecutive failure -> LOCKOUT
      start_entry(4'b0101);
      drive_entry(4'b1111, 8'b0001_0000, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_fail(2);
      for (int i = 0; i < LOCKOUT_CYCLES; i++) begin
         check_val("lockout_led", 32'(led), 32'((((i / (WINDOW_CYCLES / 2)) % 2) == 0) ? RED : OFF));
         check_val("lockout_flag", 32'(locked_out), 32'd1);
         start_pulse = (i < LOCKOUT_CYCLES - 2);
         tick();
      end
      start_pulse = 1'b0;
      expect_idle(0);
`else
      // Without lockout: failures keep returning to IDLE, attempts saturates
      start_entry(4'b0101);
      drive_entry(4'b1111, 8'b0001_0000, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_fail(2);
      expect_idle(2);
      start_entry(4'b0101);
      drive_entry(4'b0100, 8'b0000_0100, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_fail(2);
      expect_idle(2);
`endif

      // Multiple presses per window still read as a single 1; success clears attempts
      start_entry(4'b0101);
      drive_entry(4'b0101, 8'b0100_1010, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_success();

      // One failure so reset has a non-zero count to clear
      start_entry(4'b0101);
      drive_entry(4'b0001, 8'b0000_0001, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_fail(1);
      expect_idle(1);

      // Reset mid-window 2, with a press arriving in the same cycle
      start_entry(4'b0101);
      drive_entry(4'b0101, 8'b0000_0010, 2 * WINDOW_CYCLES + 3, 1'b0);
      rst       = 1'b1;
      bit_pulse = 1'b1;
      tick();
      rst       = 1'b0;
      bit_pulse = 1'b0;
      check_val("midrst_led", 32'(led), 32'(OFF));
      check_val("midrst_unlocked", 32'(unlocked), 32'd0);
      check_val("midrst_locked_out", 32'(locked_out), 32'd0);
      check_val("midrst_attempts", 32'(attempts), 32'd0);
      tick();
      check_val("midrst_idle_led", 32'(led), 32'(OFF));

      // Fresh entry with a different secret succeeds
      start_entry(4'b1010);
      drive_entry(4'b1010, 8'b0000_0001, PW_LEN * WINDOW_CYCLES, 1'b0);
      expect_success();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
